hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 131 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard: tracks in-flight loads per register, generates
// pipeline stall controls, counts consecutive stalls and raises a sticky watchdog.
module hazard_scoreboard #(
   parameter int REG_ADDR_W         = 4,
   parameter int LOAD_LATENCY       = 1,
   parameter int ZERO_REG_HARDWIRED = 1,
   parameter int MAX_STALL          = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  id_ex_valid,
   input  logic                  id_ex_memRead,
   input  logic [REG_ADDR_W-1:0] id_ex_registerRD,
   input  logic [REG_ADDR_W-1:0] if_id_registerA,
   input  logic [REG_ADDR_W-1:0] if_id_registerB,
   input  logic                  if_id_useA,
   input  logic                  if_id_useB,
   output logic                  enablePC,
   output logic                  if_id_write,
   output logic                  muxSelector,
   output logic [7:0]            stall_cycles,
   output logic                  stall_timeout,
   output logic [1:0]            state
);

   localparam int         NUM_REGS    = 1 << REG_ADDR_W;
   localparam logic [2:0] CNT_RELOAD  = 3'(LOAD_LATENCY - 1);
   localparam logic [8:0] STALL_LIMIT = 9'(MAX_STALL);

   localparam logic [1:0] ST_RUN     = 2'd0;
   localparam logic [1:0] ST_STALL   = 2'd1;
   localparam logic [1:0] ST_TIMEOUT = 2'd2;

   logic [NUM_REGS-1:0] r_pending;
   logic [2:0]          r_cnt [NUM_REGS];
   logic [7:0]          r_stall_cycles;
   logic [1:0]          r_state;

   logic                w_rd_nonzero;
   logic                w_load_issue;
   logic                w_match_a;
   logic                w_match_b;
   logic                w_stall;
   logic [8:0]          w_stall_sum;
   logic [1:0]          w_state_next;

   // A load that is squashed by flush, or targets a hardwired zero register, never creates a hazard.
   always_comb begin
      w_rd_nonzero = (ZERO_REG_HARDWIRED == 0) || (id_ex_registerRD != {REG_ADDR_W{1'b0}});
      w_load_issue = id_ex_valid && id_ex_memRead && !flush && w_rd_nonzero;
      w_match_a    = if_id_useA &&
                     ((w_load_issue && (id_ex_registerRD == if_id_registerA)) ||
                      r_pending[if_id_registerA]);
      w_match_b    = if_id_useB &&
                     ((w_load_issue && (id_ex_registerRD == if_id_registerB)) ||
                      r_pending[if_id_registerB]);
      w_stall      = (w_match_a || w_match_b) && !reset && !flush;
      w_stall_sum  = {1'b0, r_stall_cycles} + 9'd1;
   end

   genvar g;
   generate
      for (g = 0; g < NUM_REGS; g++) begin : g_reg
         localparam logic [REG_ADDR_W-1:0] REG_IDX = REG_ADDR_W'(g);

         // Per-register countdown; a fresh load reloads the counter ahead of the decrement.
         always_ff @(posedge clock) begin
            if (reset || flush) begin
               r_pending[g] <= 1'b0;
               r_cnt[g]     <= 3'd0;
            end else if (w_load_issue && (id_ex_registerRD == REG_IDX) && (LOAD_LATENCY > 1)) begin
               r_pending[g] <= 1'b1;
               r_cnt[g]     <= CNT_RELOAD;
            end else if (r_pending[g]) begin
               if (r_cnt[g] > 3'd1) begin
                  r_cnt[g] <= r_cnt[g] - 3'd1;
               end else begin
                  r_pending[g] <= 1'b0;
                  r_cnt[g]     <= 3'd0;
               end
            end else begin
               r_pending[g] <= 1'b0;
               r_cnt[g]     <= r_cnt[g];
            end
         end
      end
   endgenerate

   // Flush forces the stall off, so STALL falls back to RUN without a dedicated arc.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_RUN: begin
            if (w_stall) w_state_next = ST_STALL;
            else         w_state_next = ST_RUN;
         end
         ST_STALL: begin
            if (!w_stall)                        w_state_next = ST_RUN;
            else if (w_stall_sum >= STALL_LIMIT) w_state_next = ST_TIMEOUT;
            else                                 w_state_next = ST_STALL;
         end
         ST_TIMEOUT: w_state_next = ST_TIMEOUT;
         default:    w_state_next = ST_RUN;
      endcase
   end

   // State register and saturating consecutive-stall counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state        <= ST_RUN;
         r_stall_cycles <= 8'd0;
      end else begin
         r_state <= w_state_next;
         if (w_stall) begin
            if (r_stall_cycles != 8'd255) r_stall_cycles <= r_stall_cycles + 8'd1;
            else                          r_stall_cycles <= r_stall_cycles;
         end else begin
            r_stall_cycles <= 8'd0;
         end
      end
   end

   assign muxSelector   = w_stall;
   assign enablePC      = ~w_stall;
   assign if_id_write   = ~w_stall;
   assign stall_cycles  = r_stall_cycles;
   assign state         = r_state;
   assign stall_timeout = (r_state == ST_TIMEOUT);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: three instances (latency 1, latency 3,
// latency 3 with a short watchdog) share one stimulus stream.
module tb_hazard_scoreboard;

   logic       clock = 1'b0;
   logic       reset;
   logic       flush;
   logic       id_ex_valid;
   logic       id_ex_memRead;
   logic [3:0] id_ex_registerRD;
   logic [3:0] if_id_registerA;
   logic [3:0] if_id_registerB;
   logic       if_id_useA;
   logic       if_id_useB;

   logic       l1_pc, l1_ifw, l1_mux, l1_to;
   logic [7:0] l1_sc;
   logic [1:0] l1_st;
   logic       l3_pc, l3_ifw, l3_mux, l3_to;
   logic [7:0] l3_sc;
   logic [1:0] l3_st;
   logic       to_pc, to_ifw, to_mux, to_to;
   logic [7:0] to_sc;
   logic [1:0] to_st;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   hazard_scoreboard #(.REG_ADDR_W(4), .LOAD_LATENCY(1), .ZERO_REG_HARDWIRED(1), .MAX_STALL(16)) u_l1 (
      .clock(clock), .reset(reset), .flush(flush), .id_ex_valid(id_ex_valid),
      .id_ex_memRead(id_ex_memRead), .id_ex_registerRD(id_ex_registerRD),
      .if_id_registerA(if_id_registerA), .if_id_registerB(if_id_registerB),
      .if_id_useA(if_id_useA), .if_id_useB(if_id_useB),
      .enablePC(l1_pc), .if_id_write(l1_ifw), .muxSelector(l1_mux),
      .stall_cycles(l1_sc), .stall_timeout(l1_to), .state(l1_st));

   hazard_scoreboard #(.REG_ADDR_W(4), .LOAD_LATENCY(3), .ZERO_REG_HARDWIRED(1), .MAX_STALL(16)) u_l3 (
      .clock(clock), .reset(reset), .flush(flush), .id_ex_valid(id_ex_valid),
      .id_ex_memRead(id_ex_memRead), .id_ex_registerRD(id_ex_registerRD),
      .if_id_registerA(if_id_registerA), .if_id_registerB(if_id_registerB),
      .if_id_useA(if_id_useA), .if_id_useB(if_id_useB),
      .enablePC(l3_pc), .if_id_write(l3_ifw), .muxSelector(l3_mux),
      .stall_cycles(l3_sc), .stall_timeout(l3_to), .state(l3_st));

   hazard_scoreboard #(.REG_ADDR_W(4), .LOAD_LATENCY(3), .ZERO_REG_HARDWIRED(1), .MAX_STALL(4)) u_to (
      .clock(clock), .reset(reset), .flush(flush), .id_ex_valid(id_ex_valid),
      .id_ex_memRead(id_ex_memRead), .id_ex_registerRD(id_ex_registerRD),
      .if_id_registerA(if_id_registerA), .if_id_registerB(if_id_registerB),
      .if_id_useA(if_id_useA), .if_id_useB(if_id_useB),
      .enablePC(to_pc), .if_id_write(to_ifw), .muxSelector(to_mux),
      .stall_cycles(to_sc), .stall_timeout(to_to), .state(to_st));

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] rd, input logic [3:0] a,
                        input logic [3:0] b, input logic ua, input logic ub);
      id_ex_valid      = v;
      id_ex_memRead    = v;
      id_ex_registerRD = rd;
      if_id_registerA  = a;
      if_id_registerB  = b;
      if_id_useA       = ua;
      if_id_useB       = ub;
   endtask

   task automatic idle(input int n);
      drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
      repeat (n) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      flush = 1'b0;
      drive(1'b1, 4'd3, 4'd3, 4'd0, 1'b1, 1'b0);
      tick();
      tick();
      @(negedge clock);
      checks++; if (l1_mux !== 1'b0) begin errors++; $display("FAIL reset_mux got %0b exp 0", l1_mux); end
      checks++; if (l1_pc !== 1'b1 || l1_ifw !== 1'b1) begin errors++; $display("FAIL reset_pc got %0b/%0b exp 1/1", l1_pc, l1_ifw); end
      checks++; if (l3_st !== 2'd0 || l3_sc !== 8'd0 || to_to !== 1'b0) begin
         errors++; $display("FAIL reset_state got st=%0d sc=%0d to=%0b exp 0/0/0", l3_st, l3_sc, to_to);
      end
      tick();
      reset = 1'b0;
      idle(4);
   endtask

   task automatic test_lat1();
      drive(1'b1, 4'd3, 4'd3, 4'd0, 1'b1, 1'b0);
      @(negedge clock);
      checks++; if (l1_mux !== 1'b1 || l1_pc !== 1'b0 || l1_ifw !== 1'b0) begin
         errors++; $display("FAIL lat1_stall got mux=%0b pc=%0b ifw=%0b exp 1/0/0", l1_mux, l1_pc, l1_ifw);
      end
      tick();
      drive(1'b0, 4'd0, 4'd3, 4'd0, 1'b1, 1'b0);
      @(negedge clock);
      checks++; if (l1_mux !== 1'b0 || l1_pc !== 1'b1) begin errors++; $display("FAIL lat1_release got mux=%0b pc=%0b exp 0/1", l1_mux, l1_pc); end
      checks++; if (l1_sc !== 8'd1 || l1_st !== 2'd1) begin errors++; $display("FAIL lat1_peak got sc=%0d st=%0d exp 1/1", l1_sc, l1_st); end
      tick();
      @(negedge clock);
      checks++; if (l1_sc !== 8'd0 || l1_st !== 2'd0) begin errors++; $display("FAIL lat1_after got sc=%0d st=%0d exp 0/0", l1_sc, l1_st); end
      tick();
      idle(4);
   endtask

   task automatic test_lat3();
      logic [4:0] exp_mux;
      logic [1:0] exp_st [5];
      exp_mux = 5'b00111;
      exp_st  = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
      for (int c = 0; c < 5; c++) begin
         if (c == 0) drive(1'b1, 4'd5, 4'd1, 4'd5, 1'b0, 1'b1);
         else        drive(1'b0, 4'd0, 4'd1, 4'd5, 1'b0, 1'b1);
         @(negedge clock);
         checks++; if (l3_mux !== exp_mux[c]) begin errors++; $display("FAIL lat3_mux c%0d got %0b exp %0b", c, l3_mux, exp_mux[c]); end
         checks++; if (l3_st !== exp_st[c]) begin errors++; $display("FAIL lat3_state c%0d got %0d exp %0d", c, l3_st, exp_st[c]); end
         if (c == 3) begin
            checks++; if (l3_sc !== 8'd3) begin errors++; $display("FAIL lat3_count got %0d exp 3", l3_sc); end
         end
         tick();
      end
      idle(4);
   endtask

   task automatic test_zero_reg();
      drive(1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
      @(negedge clock);
      checks++; if (l3_mux !== 1'b0 || l1_mux !== 1'b0) begin errors++; $display("FAIL zero_issue got %0b/%0b exp 0/0", l3_mux, l1_mux); end
      tick();
      drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
      @(negedge clock);
      checks++; if (l3_mux !== 1'b0) begin errors++; $display("FAIL zero_pending got %0b exp 0", l3_mux); end
      tick();
      drive(1'b1, 4'd2, 4'd2, 4'd2, 1'b0, 1'b0);
      @(negedge clock);
      checks++; if (l3_mux !== 1'b0) begin errors++; $display("FAIL nouse_issue got %0b exp 0", l3_mux); end
      tick();
      drive(1'b0, 4'd0, 4'd2, 4'd2, 1'b0, 1'b0);
      @(negedge clock);
      checks++; if (l3_mux !== 1'b0) begin errors++; $display("FAIL nouse_pending got %0b exp 0", l3_mux); end
      tick();
      drive(1'b0, 4'd0, 4'd2, 4'd2, 1'b1, 1'b0);
      @(negedge clock);
      checks++; if (l3_mux !== 1'b1) begin errors++; $display("FAIL use_pending got %0b exp 1", l3_mux); end
      tick();
      idle(3);
   endtask

   task automatic test_reload();
      logic [4:0] exp_mux;
      exp_mux = 5'b01100;
      for (int c = 0; c < 5; c++) begin
         if (c < 2) drive(1'b1, 4'd4, 4'd9, 4'd0, 1'b1, 1'b0);
         else       drive(1'b0, 4'd0, 4'd4, 4'd0, 1'b1, 1'b0);
         @(negedge clock);
         checks++; if (l3_mux !== exp_mux[c]) begin errors++; $display("FAIL reload_mux c%0d got %0b exp %0b", c, l3_mux, exp_mux[c]); end
         tick();
      end
      idle(3);
   endtask

   task automatic test_two_sources();
      logic [4:0] exp_mux;
      exp_mux = 5'b01100;
      for (int c = 0; c < 5; c++) begin
         if (c == 0)      drive(1'b1, 4'd6, 4'd1, 4'd1, 1'b0, 1'b0);
         else if (c == 1) drive(1'b1, 4'd7, 4'd1, 4'd1, 1'b0, 1'b0);
         else             drive(1'b0, 4'd0, 4'd6, 4'd7, 1'b1, 1'b1);
         @(negedge clock);
         checks++; if (l3_mux !== exp_mux[c]) begin errors++; $display("FAIL two_src_mux c%0d got %0b exp %0b", c, l3_mux, exp_mux[c]); end
         tick();
      end
      idle(3);
   endtask

   task automatic test_flush();
      drive(1'b1, 4'd6, 4'd6, 4'd0, 1'b1, 1'b0);
      @(negedge clock);
      checks++; if (l3_mux !== 1'b1) begin errors++; $display("FAIL flush_pre got %0b exp 1", l3_mux); end
      tick();
      flush = 1'b1;
      drive(1'b1, 4'd7, 4'd6, 4'd7, 1'b1, 1'b1);
      @(negedge clock);
      checks++; if (l3_mux !== 1'b0 || l3_pc !== 1'b1) begin errors++; $display("FAIL flush_force got mux=%0b pc=%0b exp 0/1", l3_mux, l3_pc); end
      tick();
      flush = 1'b0;
      drive(1'b0, 4'd0, 4'd6, 4'd7, 1'b1, 1'b1);
      @(negedge clock);
      checks++; if (l3_mux !== 1'b0) begin errors++; $display("FAIL flush_clear got %0b exp 0", l3_mux); end
      checks++; if (l3_sc !== 8'd0 || l3_st !== 2'd0) begin errors++; $display("FAIL flush_fsm got sc=%0d st=%0d exp 0/0", l3_sc, l3_st); end
      tick();
      @(negedge clock);
      checks++; if (l3_mux !== 1'b0) begin errors++; $display("FAIL flush_clear2 got %0b exp 0", l3_mux); end
      tick();
      idle(3);
   endtask

   task automatic test_timeout();
      logic [1:0] exp_st [7];
      logic [6:0] exp_mux;
      logic [6:0] exp_to;
      exp_st  = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
      exp_mux = 7'b0111111;
      exp_to  = 7'b1110000;
      for (int c = 0; c < 7; c++) begin
         if (c < 4) drive(1'b1, 4'd5, 4'd5, 4'd0, 1'b1, 1'b0);
         else       drive(1'b0, 4'd0, 4'd5, 4'd0, 1'b1, 1'b0);
         @(negedge clock);
         checks++; if (to_st !== exp_st[c]) begin errors++; $display("FAIL timeout_state c%0d got %0d exp %0d", c, to_st, exp_st[c]); end
         checks++; if (to_to !== exp_to[c]) begin errors++; $display("FAIL timeout_flag c%0d got %0b exp %0b", c, to_to, exp_to[c]); end
         checks++; if (to_mux !== exp_mux[c]) begin errors++; $display("FAIL timeout_mux c%0d got %0b exp %0b", c, to_mux, exp_mux[c]); end
         if (c == 4) begin
            checks++; if (to_sc !== 8'd4) begin errors++; $display("FAIL timeout_count got %0d exp 4", to_sc); end
         end
         tick();
      end
      drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
      @(negedge clock);
      checks++; if (to_sc !== 8'd0 || to_to !== 1'b1) begin errors++; $display("FAIL timeout_idle got sc=%0d to=%0b exp 0/1", to_sc, to_to); end
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      @(negedge clock);
      checks++; if (to_st !== 2'd2 || to_to !== 1'b1) begin errors++; $display("FAIL timeout_flush got st=%0d to=%0b exp 2/1", to_st, to_to); end
      tick();
   endtask

   task automatic test_reset_midstall();
      drive(1'b1, 4'd8, 4'd8, 4'd0, 1'b1, 1'b0);
      @(negedge clock);
      checks++; if (l3_mux !== 1'b1) begin errors++; $display("FAIL midrst_pre got %0b exp 1", l3_mux); end
      tick();
      reset = 1'b1;
      drive(1'b0, 4'd0, 4'd8, 4'd0, 1'b1, 1'b0);
      @(negedge clock);
      checks++; if (l3_mux !== 1'b0 || l3_pc !== 1'b1) begin errors++; $display("FAIL midrst_force got mux=%0b pc=%0b exp 0/1", l3_mux, l3_pc); end
      tick();
      reset = 1'b0;
      @(negedge clock);
      checks++; if (l3_mux !== 1'b0) begin errors++; $display("FAIL midrst_clear got %0b exp 0", l3_mux); end
      checks++; if (l3_st !== 2'd0 || l3_sc !== 8'd0) begin errors++; $display("FAIL midrst_fsm got st=%0d sc=%0d exp 0/0", l3_st, l3_sc); end
      checks++; if (to_st !== 2'd0 || to_to !== 1'b0) begin errors++; $display("FAIL midrst_timeout got st=%0d to=%0b exp 0/0", to_st, to_to); end
      tick();
      drive(1'b1, 4'd8, 4'd8, 4'd0, 1'b1, 1'b0);
      @(negedge clock);
      checks++; if (l3_mux !== 1'b1) begin errors++; $display("FAIL midrst_newload got %0b exp 1", l3_mux); end
      tick();
      idle(3);
   endtask

   initial begin
      test_reset();
      test_lat1();
      test_lat3();
      test_zero_reg();
      test_reload();
      test_two_sources();
      test_flush();
      test_timeout();
      test_reset_midstall();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
